pfb_multichannel_tap_accum: RTL and testbench
=============================================

// Module: pfb_multichannel_tap_accum
// PURPOSE
//  Downstream neighbour of the PFB coefficient multiplier. Consumes its unsigned
//  coefficient*sample products, tap-major per channel, and sums TAPS products per
//  channel. Emits one scaled sum per channel with channel index and frame-last flag
//  toward the FFT input stage. Valid/ready on both sides.
// PARAMETERS
//  PROD_WIDTH  23  unsigned product width from multiplier
//  TAPS        8   products summed per channel (power of 2, >=2)
//  CHANNELS    16  channels per frame (power of 2, >=2)
//  ACC_WIDTH   26  accumulator width = PROD_WIDTH+log2(TAPS); cannot overflow
//  OUT_WIDTH   16  output width; out = acc >> (ACC_WIDTH-OUT_WIDTH)
// PORTS
//  ap_clk     in   1            clock, all logic rising edge
//  ap_rst_n   in   1            synchronous reset, active low
//  in_data    in   PROD_WIDTH   product from multiplier
//  in_sof     in   1            marks tap 0 of channel 0 of a frame
//  in_valid   in   1            in_data valid
//  in_ready   out  1            block accepts in_data this cycle
//  out_data   out  OUT_WIDTH    scaled channel sum
//  out_chan   out  log2(CHANNELS) channel index of out_data
//  out_last   out  1            out_chan == CHANNELS-1
//  out_valid  out  1            output register holds a sum
//  out_ready  in   1            downstream accepts
//  err_sync   out  1            1-cycle pulse on in_sof resync mid-frame
// BEHAVIOUR
//  - Clock/reset: one clock; reset synchronous, active-low, port ap_rst_n.
//  - Reset: tap_cnt=0, chan_cnt=0, acc=0, out_valid=0, out_data=0, out_chan=0,
//    out_last=0, err_sync=0. Reset mid-sum discards partial sum and held output.
//  - in_ready = !out_valid || out_ready (single output register, no skid).
//  - Accept = in_valid && in_ready. Only accepted beats change state.
//  - tap_cnt 0..TAPS-1: on accept, tap 0 loads acc=in_data (zero-extended);
//    taps 1..TAPS-2 add acc+=in_data; wraps to 0 after TAPS-1.
//  - Last tap (tap_cnt==TAPS-1): acc+in_data is scaled into out_data; out_chan=chan_cnt,
//    out_last=(chan_cnt==CHANNELS-1), out_valid=1 next cycle; chan_cnt increments,
//    wraps CHANNELS-1 -> 0. Latency: 1 cycle after last-tap accept.
//  - Output handshake: out_valid && out_ready clears out_valid unless a new last tap
//    is accepted the same cycle, in which case the register reloads (full throughput).
//    out_* stable while out_valid && !out_ready.
//  - in_sof on accept: if tap_cnt==0 && chan_cnt==0 normal. Otherwise resync: partial
//    acc discarded, beat treated as tap 0 ch 0 (acc=in_data, tap_cnt=1, chan_cnt=0),
//    err_sync pulses 1 cycle after. Held output is unaffected.
//  - in_sof not required every frame; counters free-run.
//  - Arithmetic unsigned; ACC_WIDTH sized so max sum TAPS*(2^PROD_WIDTH-1) fits.
// CONFIGURATION
//  PFB_ACC_ROUND_EN defined: out = acc[ACC-1:ACC-OUT] + acc[ACC-OUT-1] (round half
//    up), saturating to all-ones when truncated field already all-ones.
//  PFB_ACC_ROUND_EN undefined: plain truncation out = acc[ACC-1:ACC-OUT].
// TESTING (TAPS=8, CHANNELS=4, defaults otherwise)
//  1 Reset: ap_rst_n=0 2 cycles -> out_valid=0, out_data=0, err_sync=0, in_ready=1.
//  2 4 channels x 8 products of 1024, in_sof on first, out_ready=1 -> out_data=8,
//    out_chan 0,1,2,3, out_last only on chan 3, each 1 cycle after 8th beat.
//  3 8 products of 192 (sum 1536) -> out_data=1 without PFB_ACC_ROUND_EN, 2 with;
//    8 products of 2^23-1 -> 0xFFFF in both builds (saturation).
//  4 out_ready=0 for 10 cycles while chan 0 sum held -> in_ready=0, out_* stable;
//    release -> chan 1 sum follows without loss or duplication.
//  5 in_sof asserted on tap 3 of chan 1 -> err_sync pulse, next sum out_chan=0 equal
//    to sum of 8 beats starting at the sof beat; partial chan 1 never emitted.
//  6 ap_rst_n=0 for 1 cycle at tap 5 -> out_valid=0; next 8 beats give out_chan=0.

Source files
------------

// File: rtl/pfb_multichannel_tap_accum.sv
// ---------------------------------------------------------------------------
// pfb_multichannel_tap_accum
//
// Sits after the PFB coefficient multiplier. Products arrive tap-major per
// channel: TAPS products for channel 0, then TAPS for channel 1, and so on.
// The block sums each group of TAPS products and emits one scaled sum per
// channel, tagged with its channel index and a frame-last flag, toward the
// FFT input stage.
//
// Ports
//   ap_clk, ap_rst_n   clock; synchronous active-low reset
//   in_data            unsigned product from the multiplier (PROD_WIDTH)
//   in_sof             marks tap 0 of channel 0 of a frame
//   in_valid/in_ready  input handshake
//   out_data           scaled channel sum (OUT_WIDTH)
//   out_chan           channel index of out_data
//   out_last           out_chan == CHANNELS-1
//   out_valid/out_ready output handshake
//   err_sync           one-cycle pulse after an in_sof that arrived mid-frame
//
// Configuration macro
//   PFB_ACC_ROUND_EN   defined: round half up with saturation when scaling.
//                      undefined: plain truncation.
// ---------------------------------------------------------------------------
module pfb_multichannel_tap_accum #(
  parameter int PROD_WIDTH = 23,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 16,
  parameter int ACC_WIDTH  = PROD_WIDTH + $clog2(TAPS),
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [PROD_WIDTH-1:0]       in_data,
  input  logic                        in_sof,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [$clog2(CHANNELS)-1:0] out_chan,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        err_sync
);

  localparam int TAP_W  = $clog2(TAPS);
  localparam int CHAN_W = $clog2(CHANNELS);
  localparam int SHIFT  = ACC_WIDTH - OUT_WIDTH;

  logic [TAP_W-1:0]     tap_cnt;
  logic [CHAN_W-1:0]    chan_cnt;
  logic [ACC_WIDTH-1:0] acc;

  logic                 accept;
  logic                 resync;
  logic                 last_tap;
  logic                 emit;
  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [OUT_WIDTH-1:0] scaled;

  // Single output register with no skid buffer: a new beat may enter only
  // when the register is empty or being drained this same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_tap = (tap_cnt == TAP_W'(TAPS - 1));

  // An in_sof anywhere other than tap 0 / channel 0 restarts the frame.
  // It takes priority over the last-tap emit, so a partial sum never escapes.
  assign resync   = accept && in_sof && ((tap_cnt != '0) || (chan_cnt != '0));
  assign emit     = accept && !resync && last_tap;

  assign in_ext   = ACC_WIDTH'(in_data);
  assign acc_sum  = acc + in_ext;

  // Scale the full channel sum down to OUT_WIDTH by keeping the top bits.
  // The whole-vector shift keeps every bit of acc_sum in use in both builds.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    scaled = OUT_WIDTH'(acc_sum >> SHIFT);
`ifdef PFB_ACC_ROUND_EN
    // Round half up, but hold at all-ones instead of wrapping to zero.
    if (acc_sum[SHIFT-1] && !(&scaled)) begin
      scaled = scaled + OUT_WIDTH'(1);
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      // NOTE: everything is a small register (no memory array), so all state
      // is reset; a reset mid-sum drops both the partial sum and held output.
      tap_cnt   <= '0;
      chan_cnt  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      err_sync <= resync;

      // Tap / channel counters and accumulator.
      if (resync) begin
        acc      <= in_ext;
        tap_cnt  <= TAP_W'(1);
        chan_cnt <= '0;
      end else if (accept) begin
        if (tap_cnt == '0) begin
          acc <= in_ext;
        end else if (!last_tap) begin
          acc <= acc_sum;
        end
        // TAPS and CHANNELS are powers of two, so plain increments wrap.
        tap_cnt <= tap_cnt + TAP_W'(1);
        if (last_tap) begin
          chan_cnt <= chan_cnt + CHAN_W'(1);
        end
      end

      // Output register: reload on a completed sum (even while draining, for
      // full throughput), otherwise empty it once the consumer takes it.
      if (emit) begin
        out_data  <= scaled;
        out_chan  <= chan_cnt;
        out_last  <= (chan_cnt == CHAN_W'(CHANNELS - 1));
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pfb_multichannel_tap_accum.sv
// ---------------------------------------------------------------------------
// tb_pfb_multichannel_tap_accum
//
// Directed bench for pfb_multichannel_tap_accum with TAPS=8, CHANNELS=4.
// A table of per-channel records (eight identical products each) covers the
// normal stream, scaling and saturation; hand-written sequences cover output
// backpressure, mid-frame in_sof resync and reset during a sum.
// ---------------------------------------------------------------------------
module tb_pfb_multichannel_tap_accum;

  localparam int PROD_WIDTH = 23;
  localparam int TAPS       = 8;
  localparam int CHANNELS   = 4;
  localparam int ACC_WIDTH  = 26;
  localparam int OUT_WIDTH  = 16;

`ifdef PFB_ACC_ROUND_EN
  localparam logic [15:0] EXP_192 = 16'd2;
`else
  localparam logic [15:0] EXP_192 = 16'd1;
`endif

  logic                  ap_clk = 1'b0;
  logic                  ap_rst_n;
  logic [PROD_WIDTH-1:0] in_data;
  logic                  in_sof;
  logic                  in_valid;
  logic                  in_ready;
  logic [OUT_WIDTH-1:0]  out_data;
  logic [1:0]            out_chan;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic                  err_sync;

  pfb_multichannel_tap_accum #(
    .PROD_WIDTH(PROD_WIDTH),
    .TAPS      (TAPS),
    .CHANNELS  (CHANNELS),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_sync (err_sync)
  );

  always #5 ap_clk = ~ap_clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;

  // Count output handshakes; inputs are stable at the falling edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid && out_ready) n_hs++;
  end

  typedef struct {
    logic [PROD_WIDTH-1:0] d;
    logic                  sof;
    logic [15:0]           exp_data;
    logic [1:0]            exp_chan;
    logic                  exp_last;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after
  // the accepting edge with in_valid dropped.
  task automatic send(input logic [PROD_WIDTH-1:0] d, input logic sof);
    int waits = 0;
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    while (!in_ready && waits < 100) begin
      @(posedge ap_clk); #1;
      waits++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready low for %0d cycles", waits);
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Eight identical products for one channel; the output must not appear early.
  task automatic send_chan(input logic [PROD_WIDTH-1:0] d, input logic sof_first);
    for (int t = 0; t < TAPS; t++) begin
      send(d, sof_first && (t == 0));
      if (t == TAPS - 2) check("early_valid", 32'(out_valid), 32'd0);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] exp_data,
                           input logic [1:0] exp_chan, input logic exp_last);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"},  32'(out_data),  32'(exp_data));
    check({name, "_chan"},  32'(out_chan),  32'(exp_chan));
    check({name, "_last"},  32'(out_last),  32'(exp_last));
    check({name, "_err"},   32'(err_sync),  32'd0);
  endtask

  int hs0;
  logic [15:0] held_data;

  initial begin
    in_data   = '0;
    in_sof    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ap_rst_n  = 1'b0;

    vecs[0] = '{d: 23'd1024,     sof: 1'b1, exp_data: 16'd8,      exp_chan: 2'd0, exp_last: 1'b0};
    vecs[1] = '{d: 23'd1024,     sof: 1'b0, exp_data: 16'd8,      exp_chan: 2'd1, exp_last: 1'b0};
    vecs[2] = '{d: 23'd1024,     sof: 1'b0, exp_data: 16'd8,      exp_chan: 2'd2, exp_last: 1'b0};
    vecs[3] = '{d: 23'd1024,     sof: 1'b0, exp_data: 16'd8,      exp_chan: 2'd3, exp_last: 1'b1};
    vecs[4] = '{d: 23'd192,      sof: 1'b0, exp_data: EXP_192,    exp_chan: 2'd0, exp_last: 1'b0};
    vecs[5] = '{d: 23'h7FFFFF,   sof: 1'b0, exp_data: 16'hFFFF,   exp_chan: 2'd1, exp_last: 1'b0};
    vecs[6] = '{d: 23'd3000,     sof: 1'b0, exp_data: 16'd23,     exp_chan: 2'd2, exp_last: 1'b0};
    vecs[7] = '{d: 23'd100000,   sof: 1'b0, exp_data: 16'd781,    exp_chan: 2'd3, exp_last: 1'b1};

    // Reset state.
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_err_sync",  32'(err_sync),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    ap_rst_n = 1'b1;

    // Table: normal frame, scaling, rounding and saturation.
    for (int i = 0; i < 8; i++) begin
      send_chan(vecs[i].d, vecs[i].sof);
      check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_chan, vecs[i].exp_last);
    end
    @(posedge ap_clk); #1;
    check("table_handshakes", 32'(n_hs), 32'd8);
    check("table_drained", 32'(out_valid), 32'd0);

    // Backpressure: hold chan 0 sum for 10 cycles with chan 1 beat 0 waiting.
    hs0 = n_hs;
    send_chan(23'd2048, 1'b0);
    check_out("hold_ch0", 16'd16, 2'd0, 1'b0);
    out_ready = 1'b0;
    held_data = out_data;
    in_data   = 23'd512;
    in_valid  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge ap_clk); #1;
      check("hold_in_ready", 32'(in_ready),  32'd0);
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_data",     32'(out_data),  32'(held_data));
      check("hold_chan",     32'(out_chan),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    check("release_hs", 32'(n_hs - hs0), 32'd1);
    for (int t = 1; t < TAPS; t++) send(23'd512, 1'b0);
    check_out("after_hold_ch1", 16'd4, 2'd1, 1'b0);
    @(posedge ap_clk); #1;
    check("hold_handshakes", 32'(n_hs - hs0), 32'd2);

    // Walk to chan 1 and resync on its tap 3.
    send_chan(23'd1024, 1'b0);
    check_out("pre_ch2", 16'd8, 2'd2, 1'b0);
    send_chan(23'd1024, 1'b0);
    check_out("pre_ch3", 16'd8, 2'd3, 1'b1);
    send_chan(23'd1024, 1'b0);
    check_out("pre_ch0", 16'd8, 2'd0, 1'b0);
    hs0 = n_hs;
    for (int t = 0; t < 3; t++) send(23'd4096, 1'b0);
    send(23'd1048576, 1'b1);
    check("resync_pulse", 32'(err_sync), 32'd1);
    send(23'd1024, 1'b0);
    check("resync_pulse_end", 32'(err_sync), 32'd0);
    for (int t = 0; t < 6; t++) send(23'd1024, 1'b0);
    check_out("resync_sum", 16'd1031, 2'd0, 1'b0);
    @(posedge ap_clk); #1;
    check("resync_handshakes", 32'(n_hs - hs0), 32'd2);

    // Reset for one cycle at tap 5 of chan 1.
    for (int t = 0; t < 5; t++) send(23'd1024, 1'b0);
    in_data  = 23'd1024;
    in_valid = 1'b1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    in_valid = 1'b0;
    check("midrst_valid",    32'(out_valid), 32'd0);
    check("midrst_data",     32'(out_data),  32'd0);
    check("midrst_chan",     32'(out_chan),  32'd0);
    check("midrst_in_ready", 32'(in_ready),  32'd1);
    send_chan(23'd3072, 1'b0);
    check_out("post_rst", 16'd24, 2'd0, 1'b0);

    // Reset while a sum is held by backpressure drops it.
    out_ready = 1'b0;
    @(posedge ap_clk); #1;
    check("held_before_rst", 32'(out_valid), 32'd1);
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n  = 1'b1;
    out_ready = 1'b1;
    check("held_rst_valid", 32'(out_valid), 32'd0);
    check("held_rst_data",  32'(out_data),  32'd0);
    send_chan(23'd1024, 1'b0);
    check_out("post_rst2", 16'd8, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
